// File: rtl/i2c_slave_mem_if.sv
// i2c_slave_mem_if: bus-side I2C pins and write-commit reporting for i2c_slave_mem
// scl/sda_in: bus clock and data as seen on the wire
// sda_oe: 1 pulls SDA low
// busy: high while addressed
// wr_strobe/wr_addr/wr_data: one-clk report of each committed byte
interface i2c_slave_mem_if #(parameter int MEM_AW = 8);
  logic scl, sda_in, sda_oe, busy, wr_strobe;
  logic [MEM_AW-1:0] wr_addr;
  logic [7:0] wr_data;
  modport slave (input scl, sda_in, output sda_oe, busy, wr_strobe, wr_addr, wr_data);
  modport master (output scl, sda_in, input sda_oe, busy, wr_strobe, wr_addr, wr_data);
endinterface

// File: rtl/i2c_slave_mem.sv
// i2c_slave_mem: I2C slave byte memory with address match, ACK and auto-incrementing pointer
// clk: system clock
// rstn: asynchronous active-low reset
// bus: slave modport carrying scl/sda_in, sda_oe, busy and the wr_strobe/wr_addr/wr_data commit report
module i2c_slave_mem #(
  parameter logic [6:0] SLV_ADDR = 7'b101_0001,
  parameter bit         ADDR16   = 1'b0,
  parameter int         MEM_AW   = 8
) (
  input  logic           clk,
  input  logic           rstn,
  i2c_slave_mem_if.slave bus
);
  typedef enum logic [2:0] {IDLE, DEV, IGNORE, AHI, ALO, WDATA, RDATA, RACK} state_t;
  state_t state_q, state_d;
  logic [1:0] scl_sync_q, sda_sync_q;
  logic scl_hist_q, sda_hist_q;
  logic [2:0] cnt_q, cnt_d;
  logic full_q, full_d, ack_q, ack_d, rw_q, rw_d, inc_q, inc_d;
  logic [7:0] sr_q, sr_d, hi_q, hi_d, wr_data_q, wr_data_d, cur;
  logic [6:0] rd_q, rd_d;
  logic [MEM_AW-1:0] ptr_q, ptr_d, wr_addr_q, wr_addr_d;
  logic sda_oe_q, sda_oe_d, busy_q, busy_d, wr_strobe_q, wr_strobe_d;
  logic scl_s, sda_s, scl_rise, scl_fall, sda_rise, sda_fall, start, stop;
  logic [7:0] mem [2**MEM_AW];
  assign scl_s = scl_sync_q[1];
  assign sda_s = sda_sync_q[1];
  assign scl_rise = scl_s & ~scl_hist_q;
  assign scl_fall = ~scl_s & scl_hist_q;
  assign sda_rise = sda_s & ~sda_hist_q;
  assign sda_fall = ~sda_s & sda_hist_q;
  assign start = sda_fall & scl_s;
  assign stop = sda_rise & scl_s;
  assign cur = mem[ptr_q];
  assign bus.sda_oe = sda_oe_q;
  assign bus.busy = busy_q;
  assign bus.wr_strobe = wr_strobe_q;
  assign bus.wr_addr = wr_addr_q;
  assign bus.wr_data = wr_data_q;
  always_comb begin
    state_d = state_q;
    cnt_d = cnt_q;
    full_d = full_q;
    ack_d = ack_q;
    rw_d = rw_q;
    sr_d = sr_q;
    rd_d = rd_q;
    hi_d = hi_q;
    ptr_d = inc_q ? ptr_q + 1'b1 : ptr_q;
    inc_d = 1'b0;
    sda_oe_d = sda_oe_q;
    busy_d = busy_q;
    wr_strobe_d = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    if (stop) begin
      state_d = IDLE;
      sda_oe_d = 1'b0;
      busy_d = 1'b0;
      ack_d = 1'b0;
      full_d = 1'b0;
      cnt_d = 3'd0;
    end else if (start) begin
      state_d = DEV;
      sda_oe_d = 1'b0;
      ack_d = 1'b0;
      full_d = 1'b0;
      cnt_d = 3'd0;
    end else begin
      case (state_q)
        DEV, AHI, ALO, WDATA: begin
          // full_q: eight bits shifted, the next scl_fall opens the ACK slot
          if (scl_rise && !ack_q) begin
            sr_d = {sr_q[6:0], sda_s};
            cnt_d = cnt_q + 3'd1;
            full_d = (cnt_q == 3'd7);
          end else if (scl_fall && full_q) begin
            full_d = 1'b0;
            ack_d = 1'b1;
            sda_oe_d = 1'b1;
            if (state_q == DEV) begin
              if (sr_q[7:1] == SLV_ADDR && sr_q[7:1] != 7'd0) begin
                busy_d = 1'b1;
                rw_d = sr_q[0];
              end else begin
                state_d = IGNORE;
                ack_d = 1'b0;
                sda_oe_d = 1'b0;
                busy_d = 1'b0;
              end
            end
            if (state_q == AHI) hi_d = sr_q;
            if (state_q == ALO) ptr_d = MEM_AW'({hi_q, sr_q});
            if (state_q == WDATA) begin
              wr_strobe_d = 1'b1;
              wr_addr_d = ptr_q;
              wr_data_d = sr_q;
              inc_d = 1'b1;
            end
          end else if (scl_fall && ack_q) begin
            ack_d = 1'b0;
            sda_oe_d = 1'b0;
            state_d = state_q == DEV ? (rw_q ? RDATA : (ADDR16 ? AHI : ALO)) : state_q == AHI ? ALO : WDATA;
            // a read starts driving bit 7 on the same fall that ends the address ACK
            if (state_q == DEV && rw_q) begin
              rd_d = cur[6:0];
              sda_oe_d = ~cur[7];
            end
          end
        end
        RDATA: begin
          if (scl_rise) begin
            cnt_d = cnt_q + 3'd1;
            full_d = (cnt_q == 3'd7);
          end else if (scl_fall) begin
            if (full_q) begin
              full_d = 1'b0;
              sda_oe_d = 1'b0;
              state_d = RACK;
            end else begin
              sda_oe_d = ~rd_q[6];
              rd_d = {rd_q[5:0], 1'b0};
            end
          end
        end
        RACK: begin
          if (scl_rise) begin
            if (sda_s) begin
              state_d = IGNORE;
              busy_d = 1'b0;
            end else begin
              ptr_d = ptr_q + 1'b1;
              full_d = 1'b1;
            end
          end else if (scl_fall && full_q) begin
            full_d = 1'b0;
            cnt_d = 3'd0;
            state_d = RDATA;
            rd_d = cur[6:0];
            sda_oe_d = ~cur[7];
          end
        end
        default: ;
      endcase
    end
  end
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      scl_sync_q <= 2'b11;
      sda_sync_q <= 2'b11;
      scl_hist_q <= 1'b1;
      sda_hist_q <= 1'b1;
      state_q <= IDLE;
      cnt_q <= 3'd0;
      full_q <= 1'b0;
      ack_q <= 1'b0;
      rw_q <= 1'b0;
      inc_q <= 1'b0;
      sr_q <= 8'd0;
      hi_q <= 8'd0;
      rd_q <= 7'd0;
      ptr_q <= '0;
      sda_oe_q <= 1'b0;
      busy_q <= 1'b0;
      wr_strobe_q <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= 8'd0;
    end else begin
      scl_sync_q <= {scl_sync_q[0], bus.scl};
      sda_sync_q <= {sda_sync_q[0], bus.sda_in};
      scl_hist_q <= scl_s;
      sda_hist_q <= sda_s;
      state_q <= state_d;
      cnt_q <= cnt_d;
      full_q <= full_d;
      ack_q <= ack_d;
      rw_q <= rw_d;
      inc_q <= inc_d;
      sr_q <= sr_d;
      hi_q <= hi_d;
      rd_q <= rd_d;
      ptr_q <= ptr_d;
      sda_oe_q <= sda_oe_d;
      busy_q <= busy_d;
      wr_strobe_q <= wr_strobe_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
    end
  end
  always_ff @(posedge clk) begin
    if (wr_strobe_d) mem[wr_addr_d] <= wr_data_d;
  end
endmodule

// File: tb/tb_i2c_slave_mem.sv
// tb_i2c_slave_mem: two slaves (1-byte and 2-byte addressing) on one bus against a transaction-level memory model
module tb_i2c_slave_mem;
  localparam int Q = 25;
  typedef struct packed {logic [7:0] a; logic [7:0] d;} wr_t;
  logic clk = 1'b0, rstn = 1'b0, scl_m = 1'b1, sda_m = 1'b1, sda_line;
  int tests = 0, fails = 0, str_a = 0, str_b = 0;
  logic [7:0] last_wa_a, last_wd_a, last_wa_b, last_wd_b;
  logic oe_watch = 1'b0, oe_seen = 1'b0;
  wr_t exp_a[$], exp_b[$];
  logic [7:0] mmem [2][256];
  bit mknown [2][256];
  logic [7:0] mptr [2];
  logic [7:0] wdat [4], rgot [4];
  i2c_slave_mem_if #(.MEM_AW(8)) bus_a ();
  i2c_slave_mem_if #(.MEM_AW(8)) bus_b ();
  assign sda_line = sda_m & ~bus_a.sda_oe & ~bus_b.sda_oe;
  assign bus_a.scl = scl_m;
  assign bus_a.sda_in = sda_line;
  assign bus_b.scl = scl_m;
  assign bus_b.sda_in = sda_line;
  i2c_slave_mem #(.SLV_ADDR(7'h51), .ADDR16(1'b0), .MEM_AW(8)) dut_a (.clk(clk), .rstn(rstn), .bus(bus_a));
  i2c_slave_mem #(.SLV_ADDR(7'h52), .ADDR16(1'b1), .MEM_AW(8)) dut_b (.clk(clk), .rstn(rstn), .bus(bus_b));
  always #10 clk = ~clk;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask
  always @(negedge clk) begin
    wr_t e;
    if (oe_watch && (bus_a.sda_oe || bus_b.sda_oe)) oe_seen = 1'b1;
    if (bus_a.wr_strobe) begin
      str_a++;
      last_wa_a = bus_a.wr_addr;
      last_wd_a = bus_a.wr_data;
      chk("a_strobe_expected", 32'(exp_a.size() > 0), 1);
      if (exp_a.size() > 0) begin
        e = exp_a.pop_front();
        chk("a_wr_addr", bus_a.wr_addr, e.a);
        chk("a_wr_data", bus_a.wr_data, e.d);
      end
    end
    if (bus_b.wr_strobe) begin
      str_b++;
      last_wa_b = bus_b.wr_addr;
      last_wd_b = bus_b.wr_data;
      chk("b_strobe_expected", 32'(exp_b.size() > 0), 1);
      if (exp_b.size() > 0) begin
        e = exp_b.pop_front();
        chk("b_wr_addr", bus_b.wr_addr, e.a);
        chk("b_wr_data", bus_b.wr_data, e.d);
      end
    end
  end
  function automatic logic [6:0] dev_addr(input int d);
    return d != 0 ? 7'h52 : 7'h51;
  endfunction
  function automatic logic busy_of(input int d);
    return d != 0 ? bus_b.busy : bus_a.busy;
  endfunction
  function automatic logic oe_of(input int d);
    return d != 0 ? bus_b.sda_oe : bus_a.sda_oe;
  endfunction
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic i2c_start();
    sda_m = 1'b1; tick(Q); scl_m = 1'b1; tick(Q); sda_m = 1'b0; tick(Q); scl_m = 1'b0; tick(Q);
  endtask
  task automatic i2c_stop();
    sda_m = 1'b0; tick(Q); scl_m = 1'b1; tick(Q); sda_m = 1'b1; tick(2 * Q);
  endtask
  task automatic bit_xfer(input logic b, output logic s);
    sda_m = b; tick(Q); scl_m = 1'b1; tick(Q); s = sda_line; tick(Q); scl_m = 1'b0; tick(Q);
  endtask
  task automatic wr_byte(input logic [7:0] b, output logic a);
    logic s;
    for (int i = 7; i >= 0; i--) bit_xfer(b[i], s);
    bit_xfer(1'b1, a);
  endtask
  task automatic rd_byte(input logic nack, output logic [7:0] v);
    logic s;
    for (int i = 7; i >= 0; i--) begin
      bit_xfer(1'b1, s);
      v[i] = s;
    end
    bit_xfer(nack, s);
  endtask
  task automatic send_addr(input int d, input logic [15:0] addr);
    logic a;
    i2c_start();
    wr_byte({dev_addr(d), 1'b0}, a);
    chk("dev_w_ack", a, 0);
    chk("busy_on_match", busy_of(d), 1);
    if (d != 0) begin
      wr_byte(addr[15:8], a);
      chk("addr_hi_ack", a, 0);
    end
    wr_byte(addr[7:0], a);
    chk("addr_lo_ack", a, 0);
    mptr[d] = addr[7:0];
  endtask
  task automatic do_write(input int d, input logic [15:0] addr, input int n);
    logic a;
    send_addr(d, addr);
    for (int i = 0; i < n; i++) begin
      if (d != 0) exp_b.push_back({mptr[d], wdat[i]});
      else exp_a.push_back({mptr[d], wdat[i]});
      mmem[d][mptr[d]] = wdat[i];
      mknown[d][mptr[d]] = 1'b1;
      wr_byte(wdat[i], a);
      chk("data_ack", a, 0);
      mptr[d] = mptr[d] + 8'd1;
    end
    i2c_stop();
    chk("busy_after_stop", busy_of(d), 0);
  endtask
  task automatic do_read(input int d, input bit set, input logic [15:0] addr, input int n);
    logic a;
    logic [7:0] v;
    if (set) send_addr(d, addr);
    i2c_start();
    wr_byte({dev_addr(d), 1'b1}, a);
    chk("dev_r_ack", a, 0);
    for (int i = 0; i < n; i++) begin
      rd_byte(i == n - 1, v);
      rgot[i] = v;
      if (mknown[d][mptr[d]]) chk("rd_data", v, mmem[d][mptr[d]]);
      if (i != n - 1) mptr[d] = mptr[d] + 8'd1;
    end
    chk("oe_after_nack", oe_of(d), 0);
    chk("busy_after_nack", busy_of(d), 0);
    i2c_stop();
  endtask
  initial begin
    #3000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end
  initial begin
    int d, op, n;
    logic [15:0] ad;
    logic [7:0] wv;
    logic a, s;
    mptr[0] = 8'd0;
    mptr[1] = 8'd0;
    tick(5);
    chk("rst_oe_a", bus_a.sda_oe, 0);
    chk("rst_busy_a", bus_a.busy, 0);
    chk("rst_strobe_a", bus_a.wr_strobe, 0);
    chk("rst_waddr_a", bus_a.wr_addr, 0);
    chk("rst_wdata_a", bus_a.wr_data, 0);
    chk("rst_oe_b", bus_b.sda_oe, 0);
    chk("rst_busy_b", bus_b.busy, 0);
    rstn = 1'b1;
    tick(5);
    wdat[0] = 8'hFF;
    do_write(0, 16'h00BB, 1);
    chk("t1_strobe_count", str_a, 1);
    chk("t1_wr_addr", last_wa_a, 8'hBB);
    chk("t1_wr_data", last_wd_a, 8'hFF);
    do_read(0, 1'b1, 16'h00BB, 1);
    chk("t2_read", rgot[0], 8'hFF);
    wdat[0] = 8'h11; wdat[1] = 8'h22; wdat[2] = 8'h33;
    do_write(0, 16'h00FE, 3);
    chk("t3_model_wrap", mmem[0][0], 8'h33);
    chk("t3_ptr_wrap", mptr[0], 8'h01);
    do_read(0, 1'b1, 16'h00FE, 3);
    chk("t3_rd0", rgot[0], 8'h11);
    chk("t3_rd1", rgot[1], 8'h22);
    chk("t3_rd2", rgot[2], 8'h33);
    oe_watch = 1'b1;
    i2c_start();
    wr_byte(8'hB0, a);
    chk("t4_mismatch_nack", a, 1);
    chk("t4_busy_a", bus_a.busy, 0);
    chk("t4_busy_b", bus_b.busy, 0);
    wr_byte(8'h12, a);
    chk("t4_mismatch_data_nack", a, 1);
    i2c_stop();
    i2c_start();
    wr_byte(8'h00, a);
    chk("t4_gencall_nack", a, 1);
    wr_byte(8'h55, a);
    chk("t4_gencall_data_nack", a, 1);
    i2c_stop();
    oe_watch = 1'b0;
    chk("t4_oe_never", oe_seen, 0);
    i2c_start();
    wv = 8'hA2;
    for (int i = 7; i >= 0; i--) bit_xfer(wv[i], s);
    chk("t5_ack_slot_oe", bus_a.sda_oe, 1);
    #3 rstn = 1'b0;
    #1 chk("t5_async_release", bus_a.sda_oe, 0);
    chk("t5_busy_reset", bus_a.busy, 0);
    mptr[0] = 8'd0;
    mptr[1] = 8'd0;
    tick(5);
    rstn = 1'b1;
    tick(5);
    i2c_stop();
    wdat[0] = 8'h5C;
    do_write(0, 16'h0010, 1);
    chk("t5_rewrite_addr", last_wa_a, 8'h10);
    wdat[0] = 8'h5A;
    do_write(1, 16'h00BB, 1);
    chk("t6_addr16", last_wa_b, 8'hBB);
    wdat[0] = 8'hA5;
    do_write(1, 16'h12BB, 1);
    chk("t6_drop_hi", last_wa_b, 8'hBB);
    chk("t6_data", last_wd_b, 8'hA5);
    do_read(1, 1'b1, 16'h34BB, 1);
    chk("t6_read", rgot[0], 8'hA5);
    for (int k = 0; k < 5; k++) begin
      d = int'($urandom_range(0, 1));
      op = int'($urandom_range(0, 2));
      ad = {8'($urandom), 8'(32'hF8 + $urandom_range(0, 15))};
      if (op == 0) begin
        n = int'($urandom_range(1, 3));
        for (int i = 0; i < 4; i++) wdat[i] = 8'($urandom);
        do_write(d, ad, n);
      end else if (op == 1) do_read(d, 1'b1, ad, int'($urandom_range(1, 3)));
      else do_read(d, 1'b0, 16'h0000, int'($urandom_range(1, 2)));
    end
    tick(10);
    chk("pending_a", exp_a.size(), 0);
    chk("pending_b", exp_b.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
